branch_predict_unit: RTL and testbench

BRANCH_PREDICT_UNIT -- requirements
Module: branch_predict_unit

---
 rtl/branch_pkg.sv | 35 +++
 rtl/branch_cond_eval.sv | 34 +++
 rtl/branch_predict_unit.sv | 94 +++++++++
 tb/tb_branch_predict_unit.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/branch_pkg.sv
// Shared condition-code encoding and 2-bit predictor counter states for the
// branch unit.
package branch_pkg;

  typedef enum logic [3:0] {
    NONE = 4'd0,
    BEQZ = 4'd1,
    BNEZ = 4'd2,
    BLTZ = 4'd3,
    BGEZ = 4'd4,
    JUMP = 4'd5,
    SEQ  = 4'd6,
    SLT  = 4'd7,
    SLE  = 4'd8,
    SCO  = 4'd9
  } cond_e;

  localparam logic [1:0] SNT = 2'b00;
  localparam logic [1:0] WNT = 2'b01;
  localparam logic [1:0] WT  = 2'b10;
  localparam logic [1:0] ST  = 2'b11;

  // Saturating 2-bit counter step toward the observed outcome.
  function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
    if (taken) begin
      return (ctr == ST) ? ST : ctr + 2'd1;
    end
    return (ctr == SNT) ? SNT : ctr - 2'd1;
  endfunction

  function automatic logic is_branch(input logic [3:0] cond);
    return (cond >= BEQZ) && (cond <= JUMP);
  endfunction

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational condition decode: branch taken decision and set-instruction
// result bit from the ALU flags.
module branch_cond_eval
  import branch_pkg::*;
(
  input  logic [3:0] cond,
  input  logic       SF,
  input  logic       ZF,
  input  logic       CF,
  output logic       taken,
  output logic       setrd
);

  always_comb begin
    taken = 1'b0;
    setrd = 1'b0;
    case (cond)
      BEQZ:    taken = ZF;
      BNEZ:    taken = ~ZF;
      BLTZ:    taken = SF;
      BGEZ:    taken = ZF | ~SF;
      JUMP:    taken = 1'b1;
      SEQ:     setrd = ZF;
      SLT:     setrd = SF;
      SLE:     setrd = SF | ZF;
      SCO:     setrd = CF;
      default: begin
        taken = 1'b0;
        setrd = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/branch_predict_unit.sv
// Bimodal branch predictor: 2-bit counter table looked up at fetch, trained at
// execute, with a registered redirect pulse and a saturating mispredict count.
module branch_predict_unit
  import branch_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int BHT_DEPTH = 16,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 f_valid,
  input  logic [WIDTH-1:0]     f_pc,
  output logic                 f_pred_taken,
  input  logic                 ex_valid,
  input  logic [WIDTH-1:0]     ex_pc,
  input  logic [3:0]           ex_cond,
  input  logic                 ex_pred_taken,
  input  logic [WIDTH-1:0]     ex_target,
  input  logic                 ex_sf,
  input  logic                 ex_zf,
  input  logic                 ex_cf,
  input  logic                 flush,
  output logic                 setrd,
  output logic                 r_mispredict,
  output logic [WIDTH-1:0]     r_redirect_pc,
  output logic [CNT_WIDTH-1:0] mispredict_cnt
);

  localparam int IDX_W = $clog2(BHT_DEPTH);

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_WIDTH'(1);
  endfunction

  logic [1:0]       bht [BHT_DEPTH];
  logic [IDX_W-1:0] f_idx;
  logic [IDX_W-1:0] ex_idx;
  logic             taken_p0;
  logic             qualify_p0;
  logic             mispredict_p0;
  logic [WIDTH-1:0] redirect_p0;
  logic             unused_pc;

  // Bit 0 and the bits above the index never select an entry.
  assign unused_pc = ^{f_pc, ex_pc};

  assign f_idx  = f_pc[IDX_W:1];
  assign ex_idx = ex_pc[IDX_W:1];

  branch_cond_eval u_cond (
    .cond  (ex_cond),
    .SF    (ex_sf),
    .ZF    (ex_zf),
    .CF    (ex_cf),
    .taken (taken_p0),
    .setrd (setrd)
  );

  // Read is combinational from the current table, so a same-cycle update to
  // the same entry is seen only from the next cycle on.
  assign f_pred_taken = f_valid & bht[f_idx][1];

  // ---- stage p0: resolve evaluation ----
  assign qualify_p0    = ex_valid & ~flush & is_branch(ex_cond);
  assign mispredict_p0 = qualify_p0 & (taken_p0 != ex_pred_taken);
  assign redirect_p0   = taken_p0 ? ex_target : ex_pc + WIDTH'(2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BHT_DEPTH; i++) begin
        bht[i] <= WNT;
      end
    end else if (qualify_p0) begin
      bht[ex_idx] <= ctr_next(bht[ex_idx], taken_p0);
    end
  end

  // ---- stage p1: registered redirect and statistics ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mispredict   <= 1'b0;
      r_redirect_pc  <= '0;
      mispredict_cnt <= '0;
    end else begin
      r_mispredict <= mispredict_p0;
      if (mispredict_p0) begin
        r_redirect_pc  <= redirect_p0;
        mispredict_cnt <= sat_inc(mispredict_cnt);
      end
    end
  end

endmodule

// File: tb/tb_branch_predict_unit.sv
// Scoreboard bench for branch_predict_unit: directed scenarios then random
// traffic checked against a table-of-integers reference model.
module tb_branch_predict_unit;
  import branch_pkg::*;

  localparam int W  = 16;
  localparam int D  = 16;
  localparam int CW = 4;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic          clk;
  logic          rst_n;
  logic          f_valid;
  logic [W-1:0]  f_pc;
  logic          f_pred_taken;
  logic          ex_valid;
  logic [W-1:0]  ex_pc;
  logic [3:0]    ex_cond;
  logic          ex_pred_taken;
  logic [W-1:0]  ex_target;
  logic          ex_sf, ex_zf, ex_cf;
  logic          flush;
  logic          setrd;
  logic          r_mispredict;
  logic [W-1:0]  r_redirect_pc;
  logic [CW-1:0] mispredict_cnt;

  branch_predict_unit #(.WIDTH(W), .BHT_DEPTH(D), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n), .f_valid(f_valid), .f_pc(f_pc),
    .f_pred_taken(f_pred_taken), .ex_valid(ex_valid), .ex_pc(ex_pc),
    .ex_cond(ex_cond), .ex_pred_taken(ex_pred_taken), .ex_target(ex_target),
    .ex_sf(ex_sf), .ex_zf(ex_zf), .ex_cf(ex_cf), .flush(flush),
    .setrd(setrd), .r_mispredict(r_mispredict), .r_redirect_pc(r_redirect_pc),
    .mispredict_cnt(mispredict_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { logic pred; logic srd; } comb_t;
  typedef struct { logic mp; logic [W-1:0] pc; logic [CW-1:0] cnt; } reg_t;

  comb_t comb_q[$];
  reg_t  reg_q[$];
  int checks = 0;
  int errors = 0;

  int m_bht[D];
  int m_cnt;
  int m_redir;

  function automatic bit m_taken(int c, bit sf, bit zf);
    case (c)
      1: return zf;
      2: return !zf;
      3: return sf;
      4: return zf || !sf;
      5: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic bit m_setrd(int c, bit sf, bit zf, bit cf);
    case (c)
      6: return zf;
      7: return sf;
      8: return sf || zf;
      9: return cf;
      default: return 1'b0;
    endcase
  endfunction

  function automatic int m_idx(int pc);
    return (pc / 2) % D;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < D; i++) m_bht[i] = 1;
    m_cnt = 0;
    m_redir = 0;
  endtask

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(bit fv, int fpc, bit ev, int epc, int cond, bit pt,
                       int tgt, bit sf, bit zf, bit cf, bit fl);
    f_valid = fv; f_pc = fpc[W-1:0];
    ex_valid = ev; ex_pc = epc[W-1:0]; ex_cond = cond[3:0];
    ex_pred_taken = pt; ex_target = tgt[W-1:0];
    ex_sf = sf; ex_zf = zf; ex_cf = cf; flush = fl;
  endtask

  task automatic step(bit fv, int fpc, bit ev, int epc, int cond, bit pt,
                      int tgt, bit sf, bit zf, bit cf, bit fl);
    comb_t c;
    reg_t  r;
    bit    tk;
    bit    mp;
    int    ix;
    @(negedge clk);
    drive(fv, fpc, ev, epc, cond, pt, tgt, sf, zf, cf, fl);
    c.pred = fv && (m_bht[m_idx(fpc % 65536)] >= 2);
    c.srd  = m_setrd(cond, sf, zf, cf);
    comb_q.push_back(c);
    tk = m_taken(cond, sf, zf);
    mp = 1'b0;
    if (ev && !fl && cond >= 1 && cond <= 5) begin
      ix = m_idx(epc % 65536);
      m_bht[ix] = tk ? ((m_bht[ix] == 3) ? 3 : m_bht[ix] + 1)
                     : ((m_bht[ix] == 0) ? 0 : m_bht[ix] - 1);
      if (tk != pt) begin
        mp = 1'b1;
        m_redir = tk ? (tgt % 65536) : ((epc + 2) % 65536);
        if (m_cnt < CNT_MAX) m_cnt++;
      end
    end
    r.mp = mp; r.pc = W'(m_redir); r.cnt = CW'(m_cnt);
    reg_q.push_back(r);
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic lookup(int pc);
    step(1, pc, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Reset lands between a mispredicting resolve and the edge that would latch it.
  task automatic reset_mid();
    comb_t c;
    reg_t  r;
    @(negedge clk);
    drive(0, 0, 1, 'h0E, 1, 0, 'h0100, 0, 1, 0, 0);
    c.pred = 1'b0; c.srd = 1'b0;
    comb_q.push_back(c);
    #2 rst_n = 1'b0;
    model_reset();
    r.mp = 1'b0; r.pc = '0; r.cnt = '0;
    reg_q.push_back(r);
    @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  initial begin : mon_comb
    comb_t c;
    forever begin
      @(negedge clk);
      #3;
      if (comb_q.size() > 0) begin
        c = comb_q.pop_front();
        chk("f_pred_taken", int'(f_pred_taken), int'(c.pred));
        chk("setrd", int'(setrd), int'(c.srd));
      end
    end
  end

  initial begin : mon_reg
    reg_t r;
    forever begin
      @(posedge clk);
      #1;
      if (reg_q.size() > 0) begin
        r = reg_q.pop_front();
        chk("r_mispredict", int'(r_mispredict), int'(r.mp));
        chk("r_redirect_pc", int'(r_redirect_pc), int'(r.pc));
        chk("mispredict_cnt", int'(mispredict_cnt), int'(r.cnt));
      end
    end
  end

  initial begin : stim
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    idle();
    idle();
    rst_n = 1'b1;

    lookup('h0004);
    step(0, 0, 1, 'h0004, 1, 0, 'h0040, 0, 1, 0, 0);
    lookup('h0004);
    step(0, 0, 1, 'hFFFE, 2, 1, 'h1234, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 'h0020, 1, 'h0020, 5, 1, 'h0300, 0, 0, 0, 0);
    step(1, 'h0020, 1, 'h0020, 1, 1, 'h0300, 0, 0, 0, 0);
    lookup('h0020);
    step(1, 'h0008, 1, 'h0008, 5, 0, 'h0500, 0, 0, 0, 0);
    lookup('h0008);
    step(0, 0, 1, 'h000A, 1, 0, 'h0600, 0, 1, 0, 1);
    lookup('h000A);
    step(0, 0, 1, 'h000C, 8, 0, 'h0700, 0, 1, 0, 0);
    step(0, 0, 1, 'h000C, 9, 1, 'h0700, 0, 0, 1, 0);
    lookup('h000C);
    reset_mid();
    idle();
    lookup('h0004);

    for (int n = 0; n < 1500; n++) begin
      int fpc, epc;
      fpc = ($urandom_range(0, 7) == 0) ? int'($urandom_range(16'hFFC0, 16'hFFFF))
                                       : int'($urandom_range(0, 63));
      epc = ($urandom_range(0, 7) == 0) ? int'($urandom_range(16'hFFC0, 16'hFFFF))
                                       : int'($urandom_range(0, 63));
      step($urandom_range(0, 3) != 0, fpc, $urandom_range(0, 4) != 0, epc,
           int'($urandom_range(0, 15)), $urandom_range(0, 1) == 1,
           int'($urandom_range(0, 65535)), $urandom_range(0, 1) == 1,
           $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
           $urandom_range(0, 9) == 0);
    end

    repeat (3) idle();
    @(posedge clk);
    #3;
    chk("drain", comb_q.size() + reg_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
